// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: one CW-bit carry chunk per stage, ready/valid on both sides.
// Define PIPE_ADDSUB_OVF_EN to build the signed-overflow flag; otherwise ovf is tied to 0.
module pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);
    localparam int CW = WIDTH / STAGES;

    function automatic logic [CW:0] add_chunk(input logic [CW-1:0] x,
                                              input logic [CW-1:0] y,
                                              input logic          c);
        return {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, c};
    endfunction

    logic             adv;
    logic [WIDTH-1:0] b_eff;

    // The whole pipe advances together; it only freezes when a finished result is refused.
    assign in_ready = !(out_valid && !out_ready);
    assign adv      = in_ready;
    assign b_eff    = sub ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int DW = (k + 1) * CW;

        logic [CW-1:0] a_c;
        logic [CW-1:0] b_c;
        logic          c_in;
        logic          v_in;
        logic [CW:0]   sum;
        logic [DW-1:0] r_nxt;
        logic          vld_p;
        logic          c_p;
        logic [DW-1:0] r_p;

        if (k == 0) begin : g_src
            assign a_c   = a[CW-1:0];
            assign b_c   = b_eff[CW-1:0];
            assign c_in  = ci ^ sub;
            assign v_in  = in_valid;
            assign r_nxt = sum[CW-1:0];
        end else begin : g_src
            assign a_c   = g_st[k-1].g_skew.a_p[CW-1:0];
            assign b_c   = g_st[k-1].g_skew.b_p[CW-1:0];
            assign c_in  = g_st[k-1].c_p;
            assign v_in  = g_st[k-1].vld_p;
            assign r_nxt = {sum[CW-1:0], g_st[k-1].r_p};
        end

        assign sum = add_chunk(a_c, b_c, c_in);

        // stage k: chunk k resolved, lower result chunks accumulated
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p <= 1'b0;
                c_p   <= 1'b0;
                r_p   <= '0;
            end else if (adv) begin
                vld_p <= v_in;
                c_p   <= sum[CW];
                r_p   <= r_nxt;
            end
        end

        // Operand chunks still waiting for their stage; shrinks by CW per stage.
        if (k < STAGES - 1) begin : g_skew
            localparam int UW = WIDTH - DW;

            logic [UW-1:0] a_up;
            logic [UW-1:0] b_up;
            logic [UW-1:0] a_p;
            logic [UW-1:0] b_p;

            if (k == 0) begin : g_up
                assign a_up = a[WIDTH-1:CW];
                assign b_up = b_eff[WIDTH-1:CW];
            end else begin : g_up
                assign a_up = g_st[k-1].g_skew.a_p[UW+CW-1:CW];
                assign b_up = g_st[k-1].g_skew.b_p[UW+CW-1:CW];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_p <= '0;
                    b_p <= '0;
                end else if (adv) begin
                    a_p <= a_up;
                    b_p <= b_up;
                end
            end
        end
    end

    // output stage: only real results overwrite s/co, so they hold across bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
            co        <= 1'b0;
        end else if (adv) begin
            out_valid <= g_st[STAGES-1].vld_p;
            if (g_st[STAGES-1].vld_p) begin
                s  <= g_st[STAGES-1].r_p;
                co <= g_st[STAGES-1].c_p;
            end
        end
    end

`ifdef PIPE_ADDSUB_OVF_EN
    logic ovf_p;

    // Carry into the MSB equals a^b^s at that bit, so the top chunk needs no extra split.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_p <= 1'b0;
        end else if (adv) begin
            ovf_p <= g_st[STAGES-1].a_c[CW-1] ^ g_st[STAGES-1].b_c[CW-1]
                   ^ g_st[STAGES-1].sum[CW-1] ^ g_st[STAGES-1].sum[CW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (adv && g_st[STAGES-1].vld_p) begin
            ovf <= ovf_p;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule
